// File: rtl/lc3_ea_sequencer.sv
// lc3_ea_sequencer: multi-cycle effective-address sequencer for the SLC-3 datapath.
// It decodes IR into the ADDR2/ADDR1 mux selects, forms EA = ADDR1 + ADDR2, and
// performs the memory read(s) that LD/LDR/LDI/STI need over a ready handshake.
// Optional feature: define LC3_TIMEOUT_EN to bound each read by MEM_TIMEOUT wait cycles.
module lc3_ea_sequencer
`ifdef LC3_TIMEOUT_EN
#(
    parameter int MEM_TIMEOUT = 15
)
`endif
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic [15:0] pc,
    input  logic [15:0] baser,
    input  logic        mem_rdy,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  addr2_sel,
    output logic        addr1_sel,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [15:0] ea,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        no_ea,
    output logic        err
);

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_CALC,
        S_RD1,
        S_RD2,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_ir;
    logic [15:0] r_pc;
    logic [15:0] r_baser;
    logic [1:0]  r_addr2_sel;
    logic        r_addr1_sel;
    logic [15:0] r_ea;
    logic [15:0] r_rdata;
    logic        r_no_ea;
    logic        r_err;

    logic [3:0]  w_op;
    logic [1:0]  w_dec_sel2;
    logic        w_dec_sel1;
    logic        w_dec_no_ea;
    logic [15:0] w_addr1;
    logic [15:0] w_addr2;
    logic        w_needs_read;
    logic        w_in_rd;
    logic        w_tmo;

`ifdef LC3_TIMEOUT_EN
    logic [3:0]  r_wait;
`endif

    assign w_op         = r_ir[15:12];
    assign w_needs_read = (w_op == OP_LD) || (w_op == OP_LDR) ||
                          (w_op == OP_LDI) || (w_op == OP_STI);
    assign w_in_rd      = (r_state == S_RD1) || (r_state == S_RD2);

`ifdef LC3_TIMEOUT_EN
    assign w_tmo = w_in_rd && !mem_rdy && (r_wait == 4'(MEM_TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // Opcode decode of the latched IR into mux selects and the no-EA flag
    always_comb begin
        w_dec_sel2  = 2'b11;
        w_dec_sel1  = 1'b0;
        w_dec_no_ea = 1'b0;
        case (w_op)
            OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: begin
                w_dec_sel2 = 2'b01;
                w_dec_sel1 = 1'b0;
            end
            OP_JSR: begin
                if (r_ir[11]) begin
                    w_dec_sel2 = 2'b00;
                    w_dec_sel1 = 1'b0;
                end else begin
                    w_dec_sel2 = 2'b11;
                    w_dec_sel1 = 1'b1;
                end
            end
            OP_JMP: begin
                w_dec_sel2 = 2'b11;
                w_dec_sel1 = 1'b1;
            end
            OP_LDR, OP_STR: begin
                w_dec_sel2 = 2'b10;
                w_dec_sel1 = 1'b1;
            end
            default: begin
                w_dec_sel2  = 2'b11;
                w_dec_sel1  = 1'b0;
                w_dec_no_ea = 1'b1;
            end
        endcase
    end

    // ADDR2 / ADDR1 operand muxes driven by the registered selects
    always_comb begin
        w_addr2 = '0;
        case (r_addr2_sel)
            2'b00:   w_addr2 = {{5{r_ir[10]}}, r_ir[10:0]};
            2'b01:   w_addr2 = {{7{r_ir[8]}}, r_ir[8:0]};
            2'b10:   w_addr2 = {{10{r_ir[5]}}, r_ir[5:0]};
            default: w_addr2 = '0;
        endcase
        w_addr1 = r_addr1_sel ? r_baser : r_pc;
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-derived handshake outputs
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        mem_rd       = w_in_rd;
        mem_addr     = w_in_rd ? r_ea : '0;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_CALC;
            S_CALC:   w_state_next = w_needs_read ? S_RD1 : S_DONE;
            S_RD1: begin
                if (mem_rdy) begin
                    w_state_next = (w_op == OP_LDI) ? S_RD2 : S_DONE;
                end else if (w_tmo) begin
                    w_state_next = S_DONE;
                end
            end
            S_RD2:    if (mem_rdy || w_tmo) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Operand latch, decode registers, EA computation and read-data capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ir        <= '0;
            r_pc        <= '0;
            r_baser     <= '0;
            r_addr2_sel <= '0;
            r_addr1_sel <= 1'b0;
            r_ea        <= '0;
            r_rdata     <= '0;
            r_no_ea     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ir    <= ir;
                        r_pc    <= pc;
                        r_baser <= baser;
                        r_ea    <= '0;
                        r_rdata <= '0;
                        r_no_ea <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                S_DECODE: begin
                    r_addr2_sel <= w_dec_sel2;
                    r_addr1_sel <= w_dec_sel1;
                    r_no_ea     <= w_dec_no_ea;
                end
                S_CALC: begin
                    r_ea <= w_addr1 + w_addr2;
                end
                S_RD1: begin
                    if (mem_rdy) begin
                        if ((w_op == OP_LD) || (w_op == OP_LDR)) begin
                            r_rdata <= mem_rdata;
                        end else begin
                            // LDI/STI: first read returns the pointer, which becomes the EA
                            r_ea <= mem_rdata;
                        end
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                S_RD2: begin
                    if (mem_rdy) begin
                        r_rdata <= mem_rdata;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LC3_TIMEOUT_EN
    // Per-read wait counter, restarted on every state change
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wait <= '0;
        end else if (r_state != w_state_next) begin
            r_wait <= '0;
        end else if (w_in_rd) begin
            r_wait <= r_wait + 4'd1;
        end
    end
`endif

    assign addr2_sel = r_addr2_sel;
    assign addr1_sel = r_addr1_sel;
    assign ea        = r_ea;
    assign rdata     = r_rdata;
    assign no_ea     = r_no_ea;
    assign err       = r_err;

endmodule

// File: tb/tb_lc3_ea_sequencer.sv
// Self-checking bench for lc3_ea_sequencer: directed cases plus randomized
// instructions checked against an instruction-level reference model.
module tb_lc3_ea_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] baser;
    logic        mem_rdy;
    logic [15:0] mem_rdata;
    logic [1:0]  addr2_sel;
    logic        addr1_sel;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] ea;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        no_ea;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    lc3_ea_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .ir        (ir),
        .pc        (pc),
        .baser     (baser),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata),
        .addr2_sel (addr2_sel),
        .addr1_sel (addr1_sel),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .ea        (ea),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .no_ea     (no_ea),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: what the instruction means, in ISA terms
    typedef struct {
        logic [1:0]  sel2;
        logic        sel1;
        logic        noea;
        logic [15:0] ea0;
        int          nreads;
        bit          ptr;      // first read result replaces the EA
        bit          load1;    // rdata comes from the first read
    } exp_t;

    function automatic exp_t model(input logic [15:0] i, input logic [15:0] p, input logic [15:0] b);
        exp_t e;
        int   off;
        int   base;
        logic [3:0] op;
        op = i[15:12];
        off = 0;
        base = int'(p);
        e.noea = 1'b0;
        e.sel1 = 1'b0;
        e.sel2 = 2'b11;
        if (op inside {4'h0, 4'h2, 4'h3, 4'hA, 4'hB, 4'hE}) begin
            e.sel2 = 2'b01;
            off = int'($signed(i[8:0]));
        end else if (op == 4'h4 && i[11]) begin
            e.sel2 = 2'b00;
            off = int'($signed(i[10:0]));
        end else if (op == 4'h4 || op == 4'hC) begin
            e.sel1 = 1'b1;
            base = int'(b);
        end else if (op == 4'h6 || op == 4'h7) begin
            e.sel2 = 2'b10;
            e.sel1 = 1'b1;
            base = int'(b);
            off = int'($signed(i[5:0]));
        end else begin
            e.noea = 1'b1;
        end
        e.ea0    = 16'((base + off) % 65536);
        e.nreads = (op == 4'hA) ? 2 : ((op inside {4'h2, 4'h6, 4'hB}) ? 1 : 0);
        e.ptr    = (op == 4'hA) || (op == 4'hB);
        e.load1  = (op == 4'h2) || (op == 4'h6);
        return e;
    endfunction

    // One full instruction: start at a negedge, serve reads with the given delays
    task automatic run_txn(input logic [15:0] tir, input logic [15:0] tpc, input logic [15:0] tbas,
                           input int dly0, input int dly1,
                           input logic [15:0] d0, input logic [15:0] d1, input bit noise);
        exp_t        e;
        logic [15:0] addr;
        logic [15:0] exp_ea;
        logic [15:0] exp_rd;
        e = model(tir, tpc, tbas);
        @(negedge Clk);
        start = 1'b1; ir = tir; pc = tpc; baser = tbas;
        @(negedge Clk);
        start = noise;
        if (noise) begin
            ir = 16'($urandom); pc = 16'($urandom); baser = 16'($urandom);
            mem_rdy = 1'b1; mem_rdata = 16'($urandom);
        end
        chk("busy_decode", 16'(busy), 16'd1);
        chk("ea_cleared", ea, 16'h0);
        chk("mem_rd_decode", 16'(mem_rd), 16'd0);
        @(negedge Clk);
        chk("addr2_sel", 16'(addr2_sel), 16'(e.sel2));
        chk("addr1_sel", 16'(addr1_sel), 16'(e.sel1));
        chk("done_calc", 16'(done), 16'd0);
        @(negedge Clk);
        start = 1'b0; mem_rdy = 1'b0;
        addr = e.ea0;
        for (int r = 0; r < e.nreads; r++) begin
            for (int k = 0; k < ((r == 0) ? dly0 : dly1); k++) begin
                chk("mem_rd_wait", 16'(mem_rd), 16'd1);
                chk("mem_addr_wait", mem_addr, addr);
                @(negedge Clk);
            end
            chk("mem_rd", 16'(mem_rd), 16'd1);
            chk("mem_addr", mem_addr, addr);
            chk("done_in_read", 16'(done), 16'd0);
            mem_rdy = 1'b1;
            mem_rdata = (r == 0) ? d0 : d1;
            @(posedge Clk);
            #1;
            mem_rdy = 1'b0;
            mem_rdata = 16'($urandom);
            @(negedge Clk);
            addr = d0;
        end
        exp_ea = e.ptr ? d0 : e.ea0;
        exp_rd = e.load1 ? d0 : ((e.nreads == 2) ? d1 : 16'h0);
        chk("done", 16'(done), 16'd1);
        chk("ea", ea, exp_ea);
        chk("rdata", rdata, exp_rd);
        chk("no_ea", 16'(no_ea), 16'(e.noea));
        chk("err", 16'(err), 16'd0);
        chk("mem_rd_done", 16'(mem_rd), 16'd0);
        @(negedge Clk);
        chk("done_pulse", 16'(done), 16'd0);
        chk("busy_idle", 16'(busy), 16'd0);
        chk("ea_hold", ea, exp_ea);
        chk("sel2_hold", 16'(addr2_sel), 16'(e.sel2));
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; ir = '0; pc = '0; baser = '0;
        mem_rdy = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge Clk);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_mem_rd", 16'(mem_rd), 16'd0);
        chk("rst_ea", ea, 16'h0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_sel", {13'd0, addr2_sel, addr1_sel}, 16'h0);
        chk("rst_flags", {14'd0, no_ea, err}, 16'h0);
        Reset = 1'b0;

        // LEA with negative offset, no read
        run_txn(16'hE1FE, 16'h3005, 16'h0000, 0, 0, 16'h0, 16'h0, 1'b0);
        chk("lea_ea", ea, 16'h3003);
        // LDR with memory ready two cycles late
        run_txn(16'h62BF, 16'h0000, 16'h4000, 2, 0, 16'hBEEF, 16'h0, 1'b0);
        chk("ldr_rdata", rdata, 16'hBEEF);
        // LDI: pointer read then data read
        run_txn(16'hA004, 16'h3000, 16'h0000, 1, 0, 16'h5000, 16'h1234, 1'b0);
        chk("ldi_ea", ea, 16'h5000);
        // JSR wrap-around and a no-EA opcode
        run_txn(16'h4FFF, 16'h0000, 16'h0000, 0, 0, 16'h0, 16'h0, 1'b0);
        chk("jsr_ea", ea, 16'hFFFF);
        run_txn(16'h1021, 16'h1111, 16'h2222, 0, 0, 16'h0, 16'h0, 1'b1);
        chk("add_no_ea", 16'(no_ea), 16'd1);
        // STI with zero-wait reads and start noise while busy
        run_txn(16'hB1FF, 16'h8000, 16'h0000, 0, 0, 16'hCAFE, 16'h0, 1'b1);

        // Reset while waiting in the first read
        @(negedge Clk);
        start = 1'b1; ir = 16'h2005; pc = 16'h0100;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        chk("pre_rst_mem_rd", 16'(mem_rd), 16'd1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_mem_rd", 16'(mem_rd), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_done", 16'(done), 16'd0);
        chk("abort_ea", ea, 16'h0);
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("abort_no_done", 16'(done), 16'd0);
        end

`ifdef LC3_TIMEOUT_EN
        // LD whose memory never answers
        @(negedge Clk);
        start = 1'b1; ir = 16'h2010; pc = 16'h0200;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        for (int k = 0; k < 15; k++) begin
            chk("tmo_mem_rd", 16'(mem_rd), 16'd1);
            @(negedge Clk);
        end
        chk("tmo_done", 16'(done), 16'd1);
        chk("tmo_err", 16'(err), 16'd1);
        chk("tmo_rdata", rdata, 16'h0);
        chk("tmo_mem_rd_low", 16'(mem_rd), 16'd0);
        @(negedge Clk);
`endif

        // Randomized instructions
        for (int n = 0; n < 60; n++) begin
            logic [15:0] rir;
            rir = 16'($urandom);
            run_txn(rir, 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
